// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first). Generates sclk, cs_n and
// mosi from the system clock and samples miso. Bytes arrive over a
// valid/ready handshake; several bytes can share one cs_n assertion.
// Every output is a flop. Half-period and wait counters are 16 bits wide.
`timescale 1ns/1ps
module spi_master #(
  parameter int CLK_DIV  = 4,  // sclk half-period in clk cycles, >= 2
  parameter int CS_SETUP = 4,  // cs_n fall to first sclk low half-period, >= 1
  parameter int CS_HOLD  = 4,  // last sclk fall to cs_n rise, >= 1
  parameter int BYTE_GAP = 8,  // min sclk-low cycles between bytes, >= 1
  parameter int CS_IDLE  = 4   // min cs_n-high cycles between frames, >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SHIFT   = 3'd2,
    GAP     = 3'd3,
    HOLD    = 3'd4,
    RECOVER = 3'd5
  } state_e;

  // Terminal counts: a wait of N cycles ends when the counter reads N-1.
  localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_M1 = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_M1  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_M1   = 16'(BYTE_GAP - 1);
  localparam logic [15:0] IDLE_M1  = 16'(CS_IDLE - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;        // bit index within the byte, 0 = MSB
  logic [6:0]  tx_sh_q, tx_sh_d;    // bits still to be sent after the current one
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        last_q, last_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        tx_ready_q, tx_ready_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        busy_q, busy_d;

  logic hs;        // byte accepted on this edge
  logic div_hit;   // current sclk half-period is complete
  logic byte_done; // this edge is the 8th sclk fall

  assign hs        = tx_valid && tx_ready_q;
  assign div_hit   = (cnt_q == DIV_M1);
  assign byte_done = (state_q == SHIFT) && sclk_q && div_hit && (bit_q == 3'd7);

  // State register and all registered outputs; reset discards any partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      last_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs)                   state_d = SETUP;
      SETUP:   if (cnt_q == SETUP_M1)    state_d = SHIFT;
      SHIFT:   if (byte_done)            state_d = last_q ? HOLD : GAP;
      GAP:     if (hs)                   state_d = SHIFT;
      HOLD:    if (cnt_q == HOLD_M1)     state_d = RECOVER;
      RECOVER: if (cnt_q == IDLE_M1)     state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Counters, shift registers and the next value of every registered output.
  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    cnt_d      = cnt_q + 16'd1;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    busy_d     = (state_d != IDLE);

    unique case (state_q)
      IDLE: begin
        cnt_d      = '0;
        cs_n_d     = 1'b1;
        sclk_d     = 1'b0;
        mosi_d     = 1'b0;
        tx_ready_d = 1'b1;
        if (hs) begin
          tx_sh_d    = tx_data[6:0];
          last_d     = tx_last;
          bit_d      = '0;
          cs_n_d     = 1'b0;
          mosi_d     = tx_data[7];
          tx_ready_d = 1'b0;
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_M1) cnt_d = '0;
      end

      SHIFT: begin
        if (div_hit) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising edge: capture miso in the same cycle sclk goes high.
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], miso};
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rx_valid_d = 1'b1;
              rx_data_d  = rx_sh_q;
            end else begin
              // Falling edge after bits 7..1: present the next lower bit.
              mosi_d  = tx_sh_q[6];
              tx_sh_d = {tx_sh_q[5:0], 1'b0};
            end
          end
        end
      end

      GAP: begin
        if (hs) begin
          // The first low half-period of SHIFT serves as the setup time.
          cnt_d   = '0;
          tx_sh_d = tx_data[6:0];
          last_d  = tx_last;
          bit_d   = '0;
          mosi_d  = tx_data[7];
        end else if (cnt_q == GAP_M1) begin
          // Gap satisfied: park the counter and wait indefinitely.
          cnt_d      = cnt_q;
          tx_ready_d = 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_M1) begin
          cnt_d  = '0;
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
        end
      end

      RECOVER: begin
        if (cnt_q == IDLE_M1) begin
          cnt_d      = '0;
          tx_ready_d = 1'b1;
        end
      end

      default: begin
        cnt_d  = '0;
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
      end
    endcase
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with default parameters. A small mode-0
// slave model returns programmed bytes on miso, or miso is looped to mosi.
// Offsets are counted in clk edges from the handshake edge T0; outputs are
// sampled on the falling clk edge after the edge of interest.
`timescale 1ns/1ps
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  spi_master dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  // Slave model: loads byte 0 when cs_n falls, shifts on sclk falls.
  logic [7:0] sl_bytes [4];
  logic [1:0] sl_sel      = '0;
  logic [2:0] sl_bit      = '0;
  logic       sl_miso     = 1'b0;
  logic       sl_cs_prev  = 1'b1;
  logic       sl_sck_prev = 1'b0;
  logic       loop_en     = 1'b0;

  assign miso = loop_en ? mosi : sl_miso;

  always @(negedge clk) begin
    sl_cs_prev  <= cs_n;
    sl_sck_prev <= sclk;
    if (sl_cs_prev && !cs_n) begin
      sl_sel  <= '0;
      sl_bit  <= '0;
      sl_miso <= sl_bytes[0][7];
    end else if (!cs_n && sl_sck_prev && !sclk) begin
      if (sl_bit == 3'd7) begin
        sl_sel  <= sl_sel + 2'd1;
        sl_bit  <= '0;
        sl_miso <= sl_bytes[sl_sel + 2'd1][7];
      end else begin
        sl_bit  <= sl_bit + 3'd1;
        sl_miso <= sl_bytes[sl_sel][3'd6 - sl_bit];
      end
    end
  end

  // Monitors: rx_valid pulse count, cs_n-high sample count, sclk-low run length.
  int rx_cnt       = 0;
  int cs_hi_cnt    = 0;
  int low_run      = 0;
  int last_low_run = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt <= rx_cnt + 1;
    if (cs_n === 1'b1) cs_hi_cnt <= cs_hi_cnt + 1;
    if (sclk === 1'b1) begin
      if (low_run != 0) last_low_run <= low_run;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge following handshake-relative edge t.
  task automatic goto(input int t);
    while (pos < t) begin
      @(negedge clk);
      pos++;
    end
  endtask

  // Offer a byte from a falling edge; returns on the falling edge after T0.
  task automatic send(input logic [7:0] d, input logic l, input logic keep, output int waited);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    waited   = 0;
    while (tx_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("hs_ready", tx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) tx_valid = 1'b0;
    pos = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int w2;
    int c0;
    int h0;
    logic [7:0] b;

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    for (int i = 0; i < 4; i++) sl_bytes[i] = 8'h00;

    // Reset state: {cs_n,sclk,mosi,tx_ready,busy,rx_valid,rx_data}
    repeat (3) @(negedge clk);
    check("rst_outputs", {cs_n, sclk, mosi, tx_ready, busy, rx_valid, rx_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {tx_ready, busy}, 2'b10);

    // Reset while idle drops tx_ready at once; it returns one edge after release.
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_idle_outputs", {cs_n, sclk, mosi, tx_ready, busy, rx_valid, rx_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle_release", tx_ready, 1);

    // Single byte 0xA5, slave returns 0x3C.
    sl_bytes[0] = 8'h3C;
    c0 = rx_cnt;
    b  = 8'hA5;
    send(8'hA5, 1'b1, 1'b0, w);
    check("sb_t0", {cs_n, busy, tx_ready, mosi}, 4'b0101);
    goto(7);
    check("sb_sclk_before_first_rise", sclk, 0);
    for (int k = 0; k < 8; k++) begin
      goto(8 + 8 * k);
      check("sb_mosi_at_rise", {sclk, mosi}, {1'b1, b[7 - k]});
    end
    goto(67);
    check("sb_rx_valid_early", rx_valid, 0);
    goto(68);
    check("sb_rx", {rx_valid, rx_data, sclk}, {1'b1, 8'h3C, 1'b0});
    goto(69);
    check("sb_rx_valid_pulse", rx_valid, 0);
    goto(71);
    check("sb_cs_hold", cs_n, 0);
    goto(72);
    check("sb_cs_rise", {cs_n, mosi}, 2'b10);
    goto(75);
    check("sb_recover", {tx_ready, busy}, 2'b01);
    goto(76);
    check("sb_idle", {tx_ready, busy}, 2'b10);
    goto(78);
    check("sb_rx_count", rx_cnt - c0, 1);

    // Two-byte frame 0x81 then 0x7E; slave returns 0xC3 then 0x5A.
    sl_bytes[0] = 8'hC3;
    sl_bytes[1] = 8'h5A;
    c0 = rx_cnt;
    send(8'h81, 1'b0, 1'b0, w);
    goto(1);
    h0 = cs_hi_cnt;
    goto(68);
    check("tf_rx0", {rx_valid, rx_data, cs_n, sclk}, {1'b1, 8'hC3, 1'b0, 1'b0});
    b = 8'h7E;
    send(8'h7E, 1'b1, 1'b0, w);
    check("tf_gap_wait", w, 8);
    goto(3);
    check("tf_sclk_low", {cs_n, sclk}, 2'b00);
    for (int k = 0; k < 8; k++) begin
      goto(4 + 8 * k);
      check("tf_mosi_at_rise", {sclk, mosi}, {1'b1, b[7 - k]});
      if (k == 0) begin
        goto(5);
        check("tf_sclk_low_between_bytes", last_low_run, 13);
      end
    end
    goto(64);
    check("tf_rx1", {rx_valid, rx_data}, {1'b1, 8'h5A});
    goto(66);
    check("tf_cs_stayed_low", cs_hi_cnt - h0, 0);
    goto(68);
    check("tf_cs_rise", cs_n, 1);
    goto(72);
    check("tf_idle", {tx_ready, busy}, 2'b10);
    goto(74);
    check("tf_rx_count", rx_cnt - c0, 2);

    // GAP stall: 100 cycles with no byte offered, then 0x34 ends the frame.
    sl_bytes[0] = 8'h9E;
    sl_bytes[1] = 8'h56;
    send(8'h12, 1'b0, 1'b0, w);
    goto(68);
    check("gs_rx0", {rx_valid, rx_data}, {1'b1, 8'h9E});
    for (int i = 0; i < 100; i++) begin
      goto(76 + i);
      check("gs_stall", {cs_n, sclk, tx_ready, busy}, 4'b0011);
    end
    send(8'h34, 1'b1, 1'b0, w);
    check("gs_immediate_accept", w, 0);
    goto(4);
    check("gs_first_bit", {sclk, mosi}, 2'b10);
    goto(64);
    check("gs_rx1", {rx_valid, rx_data}, {1'b1, 8'h56});
    goto(72);
    check("gs_idle", {tx_ready, cs_n}, 2'b11);

    // Back-pressure: tx_valid held across two single-byte frames.
    sl_bytes[0] = 8'h22;
    send(8'h11, 1'b1, 1'b1, w);
    tx_data = 8'h99;
    tx_last = 1'b1;
    goto(40);
    check("bp_not_ready_mid_frame", {tx_ready, cs_n}, 2'b00);
    goto(68);
    check("bp_rx0", {rx_valid, rx_data}, {1'b1, 8'h22});
    sl_bytes[0] = 8'h44;
    goto(72);
    check("bp_cs_rise", cs_n, 1);
    w2 = 0;
    while (tx_ready !== 1'b1 && w2 < 200) begin
      @(negedge clk);
      w2++;
    end
    check("bp_cs_idle_cycles", w2, 4);
    check("bp_cs_high_at_ready", cs_n, 1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    pos = 0;
    check("bp_second_accept", {cs_n, tx_ready, mosi}, 3'b001);
    goto(8);
    check("bp_bit7", {sclk, mosi}, 2'b11);
    goto(16);
    check("bp_bit6", {sclk, mosi}, 2'b10);
    goto(68);
    check("bp_rx1", {rx_valid, rx_data}, {1'b1, 8'h44});
    goto(76);
    check("bp_idle", tx_ready, 1);

    // Reset after the 3rd sclk rise of a byte.
    sl_bytes[0] = 8'hA5;
    send(8'hC0, 1'b1, 1'b0, w);
    c0 = rx_cnt;
    goto(24);
    check("mr_third_rise", {sclk, cs_n}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mr_outputs", {cs_n, sclk, mosi, tx_ready, busy, rx_valid, rx_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    repeat (70) @(negedge clk);
    check("mr_no_rx_valid", rx_cnt - c0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_release_ready", tx_ready, 1);

    // Loopback mosi -> miso.
    loop_en = 1'b1;
    send(8'hFF, 1'b1, 1'b0, w);
    goto(68);
    check("lb_ff", {rx_valid, rx_data}, {1'b1, 8'hFF});
    goto(76);
    send(8'h00, 1'b1, 1'b0, w);
    goto(68);
    check("lb_00", {rx_valid, rx_data}, {1'b1, 8'h00});
    goto(76);
    check("lb_idle", {tx_ready, busy, cs_n}, 3'b101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master (CPOL=0, CPHA=0, MSB first) that generates `sclk`, `cs_n` and `mosi` and samples `miso`, all from the system clock. It is the host-side counterpart of the PWM generator's SPI slave bridge. It is used in host/FPGA-controller builds and as the bench driver for register access. Each byte is transferred over a valid/ready handshake, and a frame may span several bytes under one `cs_n` assertion. Timing margins are sized so the slave's 3-flop `clk`-domain synchroniser sees every byte.

## Interface
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles; must be ≥ 2.
- `CS_SETUP`, 4: `clk` cycles from `cs_n` falling to the start of the first `sclk` low half-period; must be ≥ 1.
- `CS_HOLD`, 4: `clk` cycles from the last `sclk` fall to `cs_n` rising; must be ≥ 1.
- `BYTE_GAP`, 8: minimum `clk` cycles with `sclk` low between bytes of one frame; must be ≥ 1.
- `CS_IDLE`, 4: minimum `clk` cycles `cs_n` stays high between frames; must be ≥ 1.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: a byte is offered.
- `tx_data` in 8: byte to send; sampled only on the handshake.
- `tx_last` in 1: this byte ends the frame; sampled with `tx_data`.
- `tx_ready` out 1: the block can accept a byte.
- `rx_valid` out 1: one-cycle pulse; `rx_data` is valid.
- `rx_data` out 8: byte received on `miso`; holds until the next pulse.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `sclk` out 1: SPI clock; idles low.
- `cs_n` out 1: chip select, active low.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.

## Operation
- FSM states are IDLE, SETUP, SHIFT, GAP, HOLD and RECOVER.
- All outputs are registered. Internal counters are 16 bits wide.
- A handshake occurs on a `clk` edge with `tx_valid && tx_ready`. `tx_valid` must be held until accepted. `tx_valid` while `tx_ready`=0 is ignored.
- IDLE:
  - `tx_ready`=1, `cs_n`=1, `sclk`=0, `mosi`=0.
  - Handshake: latch the byte and `last`, drive `cs_n`=0 and `mosi`=bit7, go to SETUP.
- SETUP: wait `CS_SETUP` cycles, then go to SHIFT.
- SHIFT: 8 bits, each bit being `sclk` low for `CLK_DIV` cycles then high for `CLK_DIV` cycles.
  - `miso` is captured into the rx shift register on the same edge that raises `sclk`.
  - `mosi` advances to the next lower bit on the edges that lower `sclk` after bits 7 through 1.
  - On the 8th `sclk` fall: `rx_valid`=1 for one cycle and `rx_data` is updated. Then go to HOLD if `last`, otherwise to GAP.
- GAP:
  - `cs_n`=0, `sclk`=0. `tx_ready` rises once `BYTE_GAP` cycles have elapsed.
  - Waits indefinitely for a byte.
  - Handshake: latch the byte, `mosi`=bit7, go straight to SHIFT; the first low half-period provides the setup time.
- HOLD: after `CS_HOLD` cycles, set `cs_n`=1 and `mosi`=0, go to RECOVER.
- RECOVER: after `CS_IDLE` cycles, go to IDLE.
- `busy`=1 in every state except IDLE.
- Reset, asynchronous and including mid-frame:
  - `cs_n`=1, `sclk`=0, `mosi`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0x00, `busy`=0, FSM=IDLE.
  - Any partial byte is discarded and no `rx_valid` is produced.
  - `tx_ready` rises on the first `clk` edge after `rst_n` is released.

## Timing
- Let D=`CLK_DIV`, S=`CS_SETUP`, and T0 = the handshake edge in IDLE. Then:
  - `cs_n` falls at T0.
  - The k-th `sclk` rise (k=1..8) is at T0+S+D+(k−1)·2D.
  - The k-th `sclk` fall is D cycles after the k-th rise.
  - `rx_valid` is on the edge T0+S+16D.
- `cs_n` rises `CS_HOLD` cycles after the `rx_valid` edge. `tx_ready` returns `CS_IDLE` cycles after `cs_n` rises.
- With defaults: first rise at T0+8, `rx_valid` at T0+68, `cs_n` high at T0+72, `tx_ready` at T0+76.
- For a next byte accepted in GAP at edge Tg: first rise at Tg+D, `rx_valid` at Tg+16D.
- `mosi` is stable for ≥ D cycles before every `sclk` rise. `miso` is sampled ≥ D cycles after the preceding `sclk` fall.

## Test plan
- **Reset:** assert `rst_n`=0 mid-idle → outputs `cs_n`=1, `sclk`=0, `mosi`=0, `tx_ready`=0, `busy`=0, `rx_data`=0x00. Release → `tx_ready`=1 one edge later.
- **Single byte:** 0xA5 with `tx_last`=1 against a slave model returning 0x3C (defaults) → `mosi` shows 1,0,1,0,0,1,0,1 at the rises T0+8+8k. Then `rx_valid` at T0+68 with `rx_data`=0x3C, `cs_n` high at T0+72, `tx_ready` at T0+76.
- **Two-byte frame:** 0x81 (`last`=0) then 0x7E (`last`=1) → `cs_n` stays low throughout, with ≥8 cycles of `sclk` low between bytes. Two `rx_valid` pulses follow, then HOLD and RECOVER.
- **GAP stall:** after a non-last byte, withhold `tx_valid` for 100 cycles → `cs_n`=0, `sclk`=0, `tx_ready`=1, `busy`=1 for the whole stall. A later byte is then transferred correctly.
- **Back-pressure:** hold `tx_valid` continuously across two single-byte frames → the second byte is accepted only when `tx_ready`=1, and `cs_n` is high for exactly `CS_IDLE` cycles between frames.
- **Reset mid-byte and loopback:** pull `rst_n` low after the 3rd `sclk` rise → `cs_n`=1 and `sclk`=0 immediately, with no `rx_valid`. Then loop `mosi`→`miso` and send 0xFF and 0x00 → `rx_data` equals each sent byte.
